// File: rtl/lfsr_encrypt_top.sv
// Hardwired LFSR message encryptor: loads pre-length, taps and seed from DM,
// then writes 64 parity-tagged encrypted bytes to DM[64..127] and raises done.
module dat_mem (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] rd_addr,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data
);
  logic [7:0] Core [0:255];

  assign rd_data = Core[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) Core[wr_addr] <= wr_data;
  end
endmodule

module instr_rom (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [9:0] addr,
  input  logic [8:0] wr_data,
  output logic [8:0] rd_data
);
  logic [8:0] inst_rom [0:1023];

  assign rd_data = inst_rom[addr];

  always_ff @(posedge clk) begin
    if (wr_en) inst_rom[addr] <= wr_data;
  end
endmodule

module lfsr_encrypt_top (
  input  logic clk,
  input  logic rst,
  output logic done
);
  typedef enum logic [2:0] {LD_P, LD_T, LD_S, ENC, DONE} state_t;

  state_t     state, state_nx;
  logic [5:0] idx;
  logic [6:0] lfsr, taps, tap_sel, lfsr_nx;
  logic [7:0] pre_len;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic       wr_en;
  logic [7:0] src_off, src_byte;
  logic       pad;
  logic [8:0] ir_unused;

  dat_mem DM (
    .clk     (clk),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  instr_rom IR (
    .clk     (clk),
    .wr_en   (1'b0),
    .addr    ('0),
    .wr_data ('0),
    .rd_data (ir_unused)
  );

  // Positions before the preamble or past the 61-byte message read as space.
  always_comb begin
    src_off  = {2'b00, idx} - pre_len;
    pad      = ({2'b00, idx} < pre_len) || (src_off > 8'd60);
    src_byte = pad ? 8'h20 : rd_data;
  end

  always_comb begin
    rd_addr = 8'd0;
    case (state)
      LD_P:    rd_addr = 8'd61;
      LD_T:    rd_addr = 8'd62;
      LD_S:    rd_addr = 8'd63;
      ENC:     rd_addr = pad ? 8'd0 : src_off;
      default: rd_addr = 8'd0;
    endcase
  end

  always_comb begin
    tap_sel = 7'h60;
    case (rd_data)
      8'd0:    tap_sel = 7'h60;
      8'd1:    tap_sel = 7'h48;
      8'd2:    tap_sel = 7'h78;
      8'd3:    tap_sel = 7'h72;
      8'd4:    tap_sel = 7'h6A;
      8'd5:    tap_sel = 7'h69;
      8'd6:    tap_sel = 7'h5C;
      8'd7:    tap_sel = 7'h7E;
      8'd8:    tap_sel = 7'h7B;
      default: tap_sel = 7'h60;
    endcase
  end

  always_comb begin
    lfsr_nx      = {lfsr[5:0], ^(lfsr & taps)};
    wr_en        = (state == ENC);
    wr_addr      = 8'd64 + {2'b00, idx};
    wr_data[6:0] = src_byte[6:0] ^ lfsr;
    wr_data[7]   = ^wr_data[6:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      LD_P:    state_nx = LD_T;
      LD_T:    state_nx = LD_S;
      LD_S:    state_nx = ENC;
      ENC:     state_nx = (idx == 6'd63) ? DONE : ENC;
      DONE:    state_nx = DONE;
      default: state_nx = LD_P;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LD_P;
      idx     <= '0;
      lfsr    <= '0;
      taps    <= '0;
      pre_len <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LD_P: pre_len <= rd_data;
        LD_T: taps    <= tap_sel;
        LD_S: begin
          lfsr <= rd_data[6:0];
          idx  <= '0;
        end
        ENC: begin
          lfsr <= lfsr_nx;
          idx  <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign done = (state == DONE);
endmodule

// File: tb/tb_lfsr_encrypt_top.sv
// Self-checking bench for lfsr_encrypt_top using backdoor preload of DM.Core
// and a behavioural reference model of the encryption rules.
module tb_lfsr_encrypt_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [7:0] img      [0:255];
  logic [7:0] exp_out  [0:63];
  logic [7:0] prev_out [0:63];
  logic [7:0] known    [0:6] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'hE1};
  logic       d_before, d_after;

  always #5 clk = ~clk;

  lfsr_encrypt_top dut (
    .clk  (clk),
    .rst  (rst),
    .done (done)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic load_image(input int p, input int pt, input int s, input int msg_len);
    for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
    for (int a = 0; a <= 60; a++)
      img[a] = (a < msg_len) ? 8'($urandom_range(32, 126)) : 8'h20;
    img[61] = 8'(p);
    img[62] = 8'(pt);
    img[63] = 8'(s);
  endtask

  task automatic sync_image();
    for (int a = 0; a < 256; a++) dut.DM.Core[a] = img[a];
  endtask

  task automatic build_expected();
    int p, taps, l, src, c;
    int tap_tbl [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
    p    = int'(img[61]);
    taps = (int'(img[62]) <= 8) ? tap_tbl[int'(img[62])] : 'h60;
    l    = int'(img[63]) & 'h7f;
    for (int i = 0; i < 64; i++) begin
      if (i < p || (i - p) > 60) src = 'h20;
      else src = int'(img[i - p]);
      c = (src ^ l) & 'h7f;
      if ($countones(c) % 2 == 1) c = c + 'h80;
      exp_out[i] = 8'(c);
      l = ((l << 1) & 'h7e) | ($countones(l & taps) % 2);
    end
  endtask

  task automatic run_block(output logic db, output logic da);
    @(negedge clk);
    rst = 1'b1;
    repeat (66) @(posedge clk);
    #1 db = done;
    @(posedge clk);
    #1 da = done;
  endtask

  task automatic test_reset();
    apply_reset();
    load_image(10, 0, 1, 0);
    sync_image();
    repeat (3) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
      else pass_cnt++;
      total_cnt++;
      if (dut.DM.Core[64] !== img[64])
        $display("FAIL reset_nowrite: got %h expected %h", dut.DM.Core[64], img[64]);
      else pass_cnt++;
    end
  endtask

  task automatic test_known_vector();
    apply_reset();
    load_image(10, 0, 1, 0);
    sync_image();
    build_expected();
    run_block(d_before, d_after);
    total_cnt++;
    if (d_before !== 1'b0) $display("FAIL known_done_early: got %b expected 0", d_before);
    else pass_cnt++;
    total_cnt++;
    if (d_after !== 1'b1) $display("FAIL known_done_edge67: got %b expected 1", d_after);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== known[i])
        $display("FAIL known_byte[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], known[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 64; i++) begin
      prev_out[i] = exp_out[i];
      total_cnt++;
      if (dut.DM.Core[64 + i] !== exp_out[i])
        $display("FAIL known_model[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_message_m();
    apply_reset();
    load_image(10, 0, 1, 0);
    img[0] = 8'h4D;
    sync_image();
    build_expected();
    run_block(d_before, d_after);
    total_cnt++;
    if (dut.DM.Core[74] !== 8'h55)
      $display("FAIL msg_m_byte74: got %h expected 55", dut.DM.Core[74]);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== prev_out[i])
        $display("FAIL msg_m_prefix[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], prev_out[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== exp_out[i])
        $display("FAIL msg_m_model[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_seed_zero();
    apply_reset();
    load_image(12, int'($urandom_range(0, 15)), 0, 0);
    sync_image();
    run_block(d_before, d_after);
    total_cnt++;
    if (d_after !== 1'b1) $display("FAIL seed0_done: got %b expected 1", d_after);
    else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== 8'hA0)
        $display("FAIL seed0_byte[%0d]: got %h expected a0", i, dut.DM.Core[64 + i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_pattern_overflow();
    apply_reset();
    load_image(10, 0, 1, 30);
    build_expected();
    img[62] = 8'd9;
    sync_image();
    run_block(d_before, d_after);
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== exp_out[i])
        $display("FAIL pt9_as_pt0[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_long_message();
    apply_reset();
    load_image(15, int'($urandom_range(0, 8)), int'($urandom_range(1, 127)), 49);
    sync_image();
    build_expected();
    run_block(d_before, d_after);
    total_cnt++;
    if (d_after !== 1'b1) $display("FAIL long_done: got %b expected 1", d_after);
    else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== exp_out[i])
        $display("FAIL long_model[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
      else pass_cnt++;
    end
    for (int a = 0; a < 256; a++) begin
      if (a >= 64 && a < 128) continue;
      total_cnt++;
      if (dut.DM.Core[a] !== img[a])
        $display("FAIL long_untouched[%0d]: got %h expected %h", a, dut.DM.Core[a], img[a]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      apply_reset();
      load_image(int'($urandom_range(10, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 61)));
      sync_image();
      build_expected();
      run_block(d_before, d_after);
      total_cnt++;
      if (d_before !== 1'b0 || d_after !== 1'b1)
        $display("FAIL rand_done[%0d]: got %b%b expected 01", n, d_before, d_after);
      else pass_cnt++;
      for (int i = 0; i < 64; i++) begin
        total_cnt++;
        if (dut.DM.Core[64 + i] !== exp_out[i])
          $display("FAIL rand_model[%0d][%0d]: got %h expected %h", n, i, dut.DM.Core[64 + i], exp_out[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    load_image(int'($urandom_range(10, 15)), int'($urandom_range(0, 8)),
               int'($urandom_range(1, 127)), 40);
    sync_image();
    build_expected();
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL mid_rst_done: got %b expected 0", done);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (i < 27) begin
        if (dut.DM.Core[64 + i] !== exp_out[i])
          $display("FAIL mid_rst_kept[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
        else pass_cnt++;
      end else begin
        if (dut.DM.Core[64 + i] !== img[64 + i])
          $display("FAIL mid_rst_unwritten[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], img[64 + i]);
        else pass_cnt++;
      end
    end
    run_block(d_before, d_after);
    total_cnt++;
    if (d_before !== 1'b0 || d_after !== 1'b1)
      $display("FAIL mid_rst_redone: got %b%b expected 01", d_before, d_after);
    else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== exp_out[i])
        $display("FAIL mid_rst_model[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_done_hold();
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL done_hold: got %b expected 1", done);
    else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (dut.DM.Core[64 + i] !== exp_out[i])
        $display("FAIL done_idle[%0d]: got %h expected %h", i, dut.DM.Core[64 + i], exp_out[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL done_async_clear: got %b expected 0", done);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_message_m();
    test_seed_zero();
    test_pattern_overflow();
    test_long_message();
    test_random();
    test_mid_reset();
    test_done_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
